// File: rtl/alu_result_latch.sv
// Two-entry result/flag buffer behind a 16-bit ALU built from four 4-bit slices.
// Optional macro ALU_LATCH_PARITY_EN adds a per-entry parity flag on flag_p.
module alu_result_latch (
  input  logic        clk,
  input  logic        nreset,
  input  logic [15:0] f_in,
  input  logic        cn4_b,
  input  logic        aeb_in,
  input  logic        a_msb,
  input  logic        b_msb,
  input  logic        op_sub,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        flag_c,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_v,
  output logic        flag_eq,
  output logic        flag_p
);

  typedef struct packed {
    logic [15:0] data;
    logic        c;
    logic        z;
    logic        n;
    logic        v;
    logic        eq;
`ifdef ALU_LATCH_PARITY_EN
    logic        p;
`endif
  } entry_t;

  entry_t     mem [2];
  entry_t     head_q;
  entry_t     head_next;
  entry_t     new_entry;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       wr_ptr_next;
  logic       rd_ptr_next;
  logic [1:0] count;
  logic [1:0] count_next;
  logic       push;
  logic       pop;

  // Flags derived from the slice outputs at the moment of capture.
  always_comb begin
    new_entry      = '0;
    new_entry.data = f_in;
    new_entry.c    = ~cn4_b;
    new_entry.z    = (f_in == 16'h0000);
    new_entry.n    = f_in[15];
    new_entry.v    = op_sub ? ((a_msb != b_msb) && (f_in[15] != a_msb))
                            : ((a_msb == b_msb) && (f_in[15] != a_msb));
    new_entry.eq   = aeb_in;
`ifdef ALU_LATCH_PARITY_EN
    new_entry.p    = ^f_in;
`endif
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    count_next  = count;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (flush) begin
      count_next  = 2'd0;
      wr_ptr_next = 1'b0;
      rd_ptr_next = 1'b0;
    end else begin
      count_next  = count + {1'b0, push} - {1'b0, pop};
      wr_ptr_next = wr_ptr ^ push;
      rd_ptr_next = rd_ptr ^ pop;
    end
  end

  // The output register loads the upcoming head; a slot written this edge
  // is bypassed from the inputs so a lone entry appears one cycle later.
  always_comb begin
    head_next = head_q;
    if (count_next != 2'd0) begin
      if (push && (wr_ptr == rd_ptr_next))
        head_next = new_entry;
      else
        head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      head_q <= '0;
      for (int i = 0; i < 2; i++)
        mem[i] <= '0;
    end else begin
      count  <= count_next;
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      head_q <= head_next;
      if (push)
        mem[wr_ptr] <= new_entry;
    end
  end

  assign result  = head_q.data;
  assign flag_c  = head_q.c;
  assign flag_z  = head_q.z;
  assign flag_n  = head_q.n;
  assign flag_v  = head_q.v;
  assign flag_eq = head_q.eq;
`ifdef ALU_LATCH_PARITY_EN
  assign flag_p  = head_q.p;
`else
  assign flag_p  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_latch.sv
// Directed self-checking bench for alu_result_latch (honours ALU_LATCH_PARITY_EN).
module tb_alu_result_latch;

  logic        clk = 1'b0;
  logic        nreset;
  logic [15:0] f_in;
  logic        cn4_b, aeb_in, a_msb, b_msb, op_sub;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0] result;
  logic        flag_c, flag_z, flag_n, flag_v, flag_eq, flag_p;

  int checks = 0;
  int errors = 0;

  alu_result_latch dut (
    .clk(clk), .nreset(nreset), .f_in(f_in), .cn4_b(cn4_b), .aeb_in(aeb_in),
    .a_msb(a_msb), .b_msb(b_msb), .op_sub(op_sub), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flag_c(flag_c), .flag_z(flag_z),
    .flag_n(flag_n), .flag_v(flag_v), .flag_eq(flag_eq), .flag_p(flag_p)
  );

  always #5 clk = ~clk;

`ifdef ALU_LATCH_PARITY_EN
  localparam logic P7 = 1'b1;
`else
  localparam logic P7 = 1'b0;
`endif

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic [5:0] exp);
    check_output(tag, {10'h0, flag_c, flag_z, flag_n, flag_v, flag_eq, flag_p}, {10'h0, exp});
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic iv, input logic [15:0] f, input logic cb,
                                input logic eq, input logic am, input logic bm,
                                input logic sub, input logic ordy);
    in_valid = iv; f_in = f; cn4_b = cb; aeb_in = eq;
    a_msb = am; b_msb = bm; op_sub = sub; out_ready = ordy;
  endtask

  initial begin
    nreset = 1'b0; flush = 1'b0;
    apply_stimulus(0, 16'h0000, 1, 0, 0, 0, 0, 0);
    #12;
    check_output("reset_out_valid", {15'h0, out_valid}, 16'h0);
    check_output("reset_in_ready", {15'h0, in_ready}, 16'h1);
    check_output("reset_result", result, 16'h0000);
    check_flags("reset_flags", 6'b000000);
    @(negedge clk); nreset = 1'b1;
    step();
    check_output("idle_out_valid", {15'h0, out_valid}, 16'h0);

    // FFFF, A neg minus B pos: no overflow by formula; c=0 n=1
    apply_stimulus(1, 16'hFFFF, 1, 0, 1, 0, 1, 1);
    step();
    apply_stimulus(0, 16'hFFFF, 1, 0, 1, 0, 1, 1);
    check_output("sub_out_valid", {15'h0, out_valid}, 16'h1);
    check_output("sub_result", result, 16'hFFFF);
    check_flags("sub_flags", {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});

    // A pos minus B neg giving negative: overflow
    apply_stimulus(1, 16'hFFFF, 1, 0, 0, 1, 1, 1);
    step();
    apply_stimulus(0, 16'hFFFF, 1, 0, 0, 1, 1, 1);
    check_flags("sub_ovf_flags", {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});

    apply_stimulus(1, 16'h0000, 0, 1, 1, 1, 0, 1);
    step();
    apply_stimulus(0, 16'h0000, 1, 0, 0, 0, 0, 1);
    check_output("add_zero_result", result, 16'h0000);
    check_flags("add_zero_flags", {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    step();
    check_output("drained_out_valid", {15'h0, out_valid}, 16'h0);
    check_flags("hold_flags", {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});

    apply_stimulus(1, 16'h1111, 1, 0, 0, 0, 0, 0);
    step();
    f_in = 16'h2222;
    step();
    check_output("full_in_ready", {15'h0, in_ready}, 16'h0);
    check_output("full_head", result, 16'h1111);
    f_in = 16'h3333;
    step();
    in_valid = 1'b0;
    check_output("reject_head", result, 16'h1111);
    out_ready = 1'b1;
    step();
    check_output("order_second", result, 16'h2222);
    check_output("order_in_ready", {15'h0, in_ready}, 16'h1);
    step();
    check_output("order_empty", {15'h0, out_valid}, 16'h0);
    check_output("order_hold", result, 16'h2222);

    apply_stimulus(1, 16'h5555, 1, 0, 0, 0, 0, 0);
    step();
    apply_stimulus(1, 16'h4444, 1, 0, 0, 0, 0, 1);
    step();
    check_output("pushpop_head", result, 16'h4444);
    check_output("pushpop_valid", {15'h0, out_valid}, 16'h1);
    check_output("pushpop_in_ready", {15'h0, in_ready}, 16'h1);
    apply_stimulus(1, 16'h6666, 1, 0, 0, 0, 0, 0);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_output("flush_out_valid", {15'h0, out_valid}, 16'h0);
    check_output("flush_in_ready", {15'h0, in_ready}, 16'h1);
    check_output("flush_hold", result, 16'h4444);

    apply_stimulus(1, 16'h0007, 1, 0, 0, 0, 0, 0);
    step();
    check_output("par7_flag_p", {15'h0, flag_p}, {15'h0, P7});
    apply_stimulus(1, 16'h0003, 1, 0, 0, 0, 0, 1);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check_output("par3_result", result, 16'h0003);
    check_output("par3_flag_p", {15'h0, flag_p}, 16'h0);

    // Fill the buffer, then reset mid-transfer
    in_valid = 1'b1; f_in = 16'h8888;
    step();
    in_valid = 1'b0;
    check_output("pre_reset_in_ready", {15'h0, in_ready}, 16'h0);
    nreset = 1'b0;
    #1;
    check_output("async_out_valid", {15'h0, out_valid}, 16'h0);
    check_output("async_in_ready", {15'h0, in_ready}, 16'h1);
    check_output("async_result", result, 16'h0000);
    @(negedge clk); nreset = 1'b1;
    apply_stimulus(1, 16'hAAAA, 1, 0, 0, 0, 0, 0);
    step();
    in_valid = 1'b0;
    check_output("post_reset_result", result, 16'hAAAA);
    check_output("post_reset_in_ready", {15'h0, in_ready}, 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
